// File: rtl/bp_pkg.sv
// Shared branch-prediction types: BTB entry metadata, counter encodings and defaults.
package bp_pkg;

    localparam int BTB_ENTRIES_DEFAULT = 16;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Per-entry control state; tag and target live in width-parameterized arrays in the top.
    typedef struct packed {
        logic       valid;
        logic       is_jump;
        logic [1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state logic.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (up) begin
            if (ctr != ST) next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC selection with a direct-mapped BTB, EX-stage mispredict detection and redirect.
module next_pc_predictor
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] new_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    btb_entry_t       meta    [BTB_ENTRIES];
    logic [TAG_W-1:0] tags    [BTB_ENTRIES];
    logic [XLEN-1:0]  targets [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;
    logic [XLEN-1:0]  pc_plus4, ex_pc_plus4, redirect;
    logic             ctl, mispredict;
    logic [1:0]       ctr_next;

    assign pc_plus4    = pc + FOUR;
    assign ex_pc_plus4 = ex_pc + FOUR;

    // Fetch-side lookup
    assign f_idx = pc[IDX+1:2];
    assign f_tag = pc[XLEN-1:IDX+2];
    assign f_hit = meta[f_idx].valid && (tags[f_idx] == f_tag);

    assign pred_taken  = !rst && f_hit && (meta[f_idx].is_jump || meta[f_idx].ctr[1]);
    assign pred_target = pred_taken ? targets[f_idx] : pc_plus4;

    // EX-side resolution; a non-control instruction predicted taken is an alias hit
    assign ctl = ex_is_branch || ex_is_jump;

    always_comb begin
        mispredict = 1'b0;
        if (!rst && ex_valid) begin
            if (ctl)
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            else
                mispredict = ex_pred_taken;
        end
    end

    assign redirect = (ctl && ex_taken) ? ex_target : ex_pc_plus4;
    assign flush    = mispredict;

    always_comb begin
        new_pc = pc_plus4;
        if (mispredict)      new_pc = redirect;
        else if (pred_taken) new_pc = pred_target;
    end

    assign u_idx = ex_pc[IDX+1:2];
    assign u_tag = ex_pc[XLEN-1:IDX+2];
    assign u_hit = meta[u_idx].valid && (tags[u_idx] == u_tag);

    sat_counter2 u_ctr (
        .ctr  (meta[u_idx].ctr),
        .up   (ex_taken),
        .next (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) meta[i] <= '0;
        end else if (ex_valid) begin
            if (ctl && u_hit) begin
                meta[u_idx].ctr     <= ctr_next;
                meta[u_idx].is_jump <= ex_is_jump;
            end else if (ctl && ex_taken) begin
                meta[u_idx] <= '{valid: 1'b1, is_jump: ex_is_jump, ctr: WT};
            end else if (!ctl && u_hit) begin
                meta[u_idx].valid <= 1'b0;
            end
        end
    end

    // Tag/target payload carries no reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (!rst && ex_valid && ctl && ex_taken) begin
            targets[u_idx] <= ex_target;
            if (!u_hit) tags[u_idx] <= u_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid && ctl) branch_count <= branch_count + 32'd1;
            if (mispredict)      mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed self-checking bench for next_pc_predictor.
module tb_next_pc_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, new_pc, pred_target;
    logic        pred_taken;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        flush;
    logic [31:0] branch_count, mispredict_count;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    next_pc_predictor #(.XLEN(32), .BTB_ENTRIES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .new_pc           (new_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic drive_ex(input logic [31:0] epc, input logic br, input logic jmp,
                            input logic tkn, input logic [31:0] tgt,
                            input logic ptkn, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_pc = epc; ex_is_branch = br; ex_is_jump = jmp;
        ex_taken = tkn; ex_target = tgt; ex_pred_taken = ptkn; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h100;
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_target = 0;
        #1;
        assertions++; if (new_pc !== 32'h104) begin failures++; $display("FAIL rst_new_pc: got %h expected %h", new_pc, 32'h104); end
        assertions++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred_taken: got %b expected 0", pred_taken); end
        assertions++; if (pred_target !== 32'h104) begin failures++; $display("FAIL rst_pred_target: got %h expected %h", pred_target, 32'h104); end
        tick(); tick();
        rst = 1'b0; #1;
        assertions++; if (new_pc !== 32'h104) begin failures++; $display("FAIL seq_new_pc: got %h expected %h", new_pc, 32'h104); end
        assertions++; if (flush !== 1'b0) begin failures++; $display("FAIL seq_flush: got %b expected 0", flush); end
        assertions++; if (branch_count !== 0 || mispredict_count !== 0) begin failures++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count); end
    endtask

    task automatic test_allocate();
        pc = 32'h100;
        drive_ex(32'h100, 1, 0, 1, 32'h80, 0, 32'h0);
        assertions++; if (flush !== 1'b1) begin failures++; $display("FAIL alloc_flush: got %b expected 1", flush); end
        assertions++; if (new_pc !== 32'h80) begin failures++; $display("FAIL alloc_redirect: got %h expected %h", new_pc, 32'h80); end
        tick();
        assertions++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_pred_taken: got %b expected 1", pred_taken); end
        assertions++; if (new_pc !== 32'h80) begin failures++; $display("FAIL alloc_new_pc: got %h expected %h", new_pc, 32'h80); end
        assertions++; if (dut.meta[0].ctr !== 2'd2) begin failures++; $display("FAIL alloc_ctr: got %0d expected 2", dut.meta[0].ctr); end
        assertions++; if (branch_count !== 1 || mispredict_count !== 1) begin failures++; $display("FAIL alloc_counts: got %0d/%0d expected 1/1", branch_count, mispredict_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_ctr [7] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        logic       dir     [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       exp_fl  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ptk;
        pc = 32'h100;
        for (int i = 0; i < 7; i++) begin
            ptk = pred_taken;
            drive_ex(32'h100, 1, 0, dir[i], 32'h80, ptk, ptk ? 32'h80 : 32'h104);
            assertions++; if (flush !== exp_fl[i]) begin failures++; $display("FAIL sat_flush[%0d]: got %b expected %b", i, flush, exp_fl[i]); end
            tick();
            assertions++; if (dut.meta[0].ctr !== exp_ctr[i]) begin failures++; $display("FAIL sat_ctr[%0d]: got %0d expected %0d", i, dut.meta[0].ctr, exp_ctr[i]); end
            assertions++; if (pred_taken !== exp_ctr[i][1]) begin failures++; $display("FAIL sat_pred[%0d]: got %b expected %b", i, pred_taken, exp_ctr[i][1]); end
        end
        assertions++; if (branch_count !== 8 || mispredict_count !== 4) begin failures++; $display("FAIL sat_counts: got %0d/%0d expected 8/4", branch_count, mispredict_count); end
    endtask

    task automatic test_wrong_target();
        pc = 32'h200;
        drive_ex(32'h200, 0, 1, 1, 32'h300, 0, 32'h204);
        tick();
        assertions++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin failures++; $display("FAIL jmp_pred: got %b/%h expected 1/%h", pred_taken, pred_target, 32'h300); end
        drive_ex(32'h200, 0, 1, 1, 32'h340, 1, 32'h300);
        assertions++; if (flush !== 1'b1 || new_pc !== 32'h340) begin failures++; $display("FAIL jmp_redirect: got %b/%h expected 1/%h", flush, new_pc, 32'h340); end
        tick();
        assertions++; if (pred_target !== 32'h340 || new_pc !== 32'h340) begin failures++; $display("FAIL jmp_retarget: got %h/%h expected %h", pred_target, new_pc, 32'h340); end
        pc = 32'h100; #1;
        assertions++; if (pred_taken !== 1'b0 || new_pc !== 32'h104) begin failures++; $display("FAIL evicted_lookup: got %b/%h expected 0/%h", pred_taken, new_pc, 32'h104); end
        assertions++; if (branch_count !== 10 || mispredict_count !== 6) begin failures++; $display("FAIL jmp_counts: got %0d/%0d expected 10/6", branch_count, mispredict_count); end
    endtask

    task automatic test_alias_wrap();
        pc = 32'h400;
        drive_ex(32'h400, 1, 0, 1, 32'h500, 0, 32'h404);
        tick();
        assertions++; if (pred_taken !== 1'b1 || new_pc !== 32'h500) begin failures++; $display("FAIL alias_setup: got %b/%h expected 1/%h", pred_taken, new_pc, 32'h500); end
        drive_ex(32'h400, 0, 0, 0, 32'h0, 1, 32'h500);
        assertions++; if (flush !== 1'b1 || new_pc !== 32'h404) begin failures++; $display("FAIL alias_redirect: got %b/%h expected 1/%h", flush, new_pc, 32'h404); end
        tick();
        assertions++; if (pred_taken !== 1'b0 || new_pc !== 32'h404) begin failures++; $display("FAIL alias_invalid: got %b/%h expected 0/%h", pred_taken, new_pc, 32'h404); end
        assertions++; if (branch_count !== 11 || mispredict_count !== 8) begin failures++; $display("FAIL alias_counts: got %0d/%0d expected 11/8", branch_count, mispredict_count); end
        pc = 32'hFFFF_FFFC; #1;
        assertions++; if (new_pc !== 32'h0 || pred_target !== 32'h0) begin failures++; $display("FAIL pc_wrap: got %h/%h expected 0", new_pc, pred_target); end
    endtask

    task automatic test_reset_mid();
        pc = 32'h800;
        rst = 1'b1;
        drive_ex(32'h800, 1, 0, 1, 32'h900, 0, 32'h804);
        assertions++; if (flush !== 1'b0 || new_pc !== 32'h804) begin failures++; $display("FAIL mid_rst_comb: got %b/%h expected 0/%h", flush, new_pc, 32'h804); end
        tick();
        rst = 1'b0; #1;
        assertions++; if (pred_taken !== 1'b0 || new_pc !== 32'h804) begin failures++; $display("FAIL mid_rst_lookup: got %b/%h expected 0/%h", pred_taken, new_pc, 32'h804); end
        assertions++; if (branch_count !== 0 || mispredict_count !== 0) begin failures++; $display("FAIL mid_rst_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_wrong_target();
        test_alias_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
